usb3_pkt_tx: RTL and testbench

- Transmit-side framer for the USB3 slave-FIFO link; the reverse of the receive-side cache and packet-type decoder.
- Sends one header word, then PKT_WORDS payload words from a local source FIFO, then strobes PKTEND.
- Drives the FX3 slave-FIFO write interface, honouring the FIFO-full flag.
- Sits between the capture/readback FIFO and the USB3 pins.

---
 rtl/usb3_pkt_tx.sv | 174 +++++++++++++++++
 tb/tb_usb3_pkt_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/usb3_pkt_tx.sv
// USB3 slave-FIFO transmit framer: header word, PKT_WORDS payload words, then PKTEND.
// Optional trailing checksum word when TX_CSUM_EN is defined.
module usb3_pkt_tx #(
    parameter int PKT_WORDS = 256,
    parameter int DW        = 32
) (
    input  logic          wrclock,
    input  logic          rst_n,
    input  logic          pkt_req,
    input  logic [4:0]    pkt_type,
    output logic          busy,
    output logic          pkt_done,
    output logic          type_err,
    output logic          hdr_alias,
    input  logic [DW-1:0] src_data,
    input  logic          src_valid,
    output logic          src_rd,
    input  logic          USB3_FLAGB,
    output logic [DW-1:0] USB3_DQ,
    output logic          USB3_SLWR_n,
    output logic          USB3_PKTEND_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
`ifdef TX_CSUM_EN
        S_CSUM,
`endif
        S_PEND,
        S_DONE
    } state_t;

    localparam logic [8:0]    LAST_CNT   = 9'(PKT_WORDS);
    localparam logic [DW-1:0] ALIAS_MASK = 32'hFF00_00FF;

    state_t        state, state_nxt;
    logic [2:0]    type_q, type_d;
    logic [8:0]    word_cnt, cnt_d;
    logic [DW-1:0] dq_d;
    logic          slwr_d, pend_d, busy_d, done_d, terr_d, alias_d;
`ifdef TX_CSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    function automatic logic [15:0] type_code(input logic [2:0] t);
        case (t)
            3'd1:    type_code = 16'h0000;
            3'd2:    type_code = 16'h000A;
            3'd3:    type_code = 16'h0AAA;
            3'd4:    type_code = 16'hAAAA;
            3'd5:    type_code = 16'h00AA;
            default: type_code = 16'h0000;
        endcase
    endfunction

    // Pop only when the FX3 has room and the source has data; one word may
    // still land after FLAGB falls, which the watermark slack absorbs.
    assign src_rd = (state == S_PAY) && USB3_FLAGB && src_valid && (word_cnt < LAST_CNT);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        type_d    = type_q;
        cnt_d     = word_cnt;
        dq_d      = USB3_DQ;
        slwr_d    = 1'b1;
        pend_d    = 1'b1;
        busy_d    = busy;
        done_d    = 1'b0;
        terr_d    = 1'b0;
        alias_d   = 1'b0;
`ifdef TX_CSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state)
            S_IDLE: begin
                if (pkt_req) begin
                    if (pkt_type inside {[5'd1:5'd5]}) begin
                        type_d    = pkt_type[2:0];
                        busy_d    = 1'b1;
                        state_nxt = S_HDR;
                    end else begin
                        terr_d = 1'b1;
                    end
                end
            end
            S_HDR: begin
`ifdef TX_CSUM_EN
                csum_d = '0;
`endif
                if (USB3_FLAGB) begin
                    dq_d      = {8'hFF, type_code(type_q), 8'hFF};
                    slwr_d    = 1'b0;
                    state_nxt = S_PAY;
                end
            end
            S_PAY: begin
                if (src_rd) begin
                    dq_d    = src_data;
                    slwr_d  = 1'b0;
                    cnt_d   = word_cnt + 9'd1;
                    alias_d = ((src_data & ALIAS_MASK) == ALIAS_MASK);
`ifdef TX_CSUM_EN
                    csum_d  = csum_q + src_data;
`endif
                end else if (word_cnt == LAST_CNT) begin
`ifdef TX_CSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_PEND;
`endif
                end
            end
`ifdef TX_CSUM_EN
            S_CSUM: begin
                if (USB3_FLAGB) begin
                    dq_d      = csum_q;
                    slwr_d    = 1'b0;
                    state_nxt = S_PEND;
                end
            end
`endif
            S_PEND: begin
                pend_d    = 1'b0;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                cnt_d     = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and every
    // register is in the async reset so a mid-packet reset abandons the packet.
    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            type_q        <= '0;
            word_cnt      <= '0;
            USB3_DQ       <= '0;
            USB3_SLWR_n   <= 1'b1;
            USB3_PKTEND_n <= 1'b1;
            busy          <= 1'b0;
            pkt_done      <= 1'b0;
            type_err      <= 1'b0;
            hdr_alias     <= 1'b0;
`ifdef TX_CSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state         <= state_nxt;
            type_q        <= type_d;
            word_cnt      <= cnt_d;
            USB3_DQ       <= dq_d;
            USB3_SLWR_n   <= slwr_d;
            USB3_PKTEND_n <= pend_d;
            busy          <= busy_d;
            pkt_done      <= done_d;
            type_err      <= terr_d;
            hdr_alias     <= alias_d;
`ifdef TX_CSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_usb3_pkt_tx.sv
// Directed self-checking bench for usb3_pkt_tx with PKT_WORDS=4.
module tb_usb3_pkt_tx;

    localparam int PW = 4;

    logic        wrclock = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_req = 1'b0;
    logic [4:0]  pkt_type = '0;
    logic        busy, pkt_done, type_err, hdr_alias;
    logic [31:0] src_data;
    logic        src_valid, src_rd;
    logic        USB3_FLAGB = 1'b1;
    logic [31:0] USB3_DQ;
    logic        USB3_SLWR_n, USB3_PKTEND_n;

    usb3_pkt_tx #(.PKT_WORDS(PW), .DW(32)) dut (
        .wrclock      (wrclock),
        .rst_n        (rst_n),
        .pkt_req      (pkt_req),
        .pkt_type     (pkt_type),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .type_err     (type_err),
        .hdr_alias    (hdr_alias),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_rd       (src_rd),
        .USB3_FLAGB   (USB3_FLAGB),
        .USB3_DQ      (USB3_DQ),
        .USB3_SLWR_n  (USB3_SLWR_n),
        .USB3_PKTEND_n(USB3_PKTEND_n)
    );

    always #5 wrclock = ~wrclock;

    int n_checks = 0;
    int n_fail   = 0;

    // Show-ahead source model
    logic [31:0] src_words [PW];
    int          pop_cnt = 0;
    int          src_base = 0;
    logic        src_hold = 1'b0;
    int          src_pos;
    assign src_pos   = pop_cnt - src_base;
    assign src_valid = (src_pos < PW) && !src_hold;
    assign src_data  = (src_pos >= 0 && src_pos < PW) ? src_words[src_pos] : 32'h0;

    always @(posedge wrclock) if (src_rd) pop_cnt <= pop_cnt + 1;

    // Bus monitor
    logic [31:0] wr_q [$];
    int pend_cnt = 0, done_cnt = 0, terr_cnt = 0, alias_cnt = 0;

    always @(negedge wrclock) begin
        if (!USB3_SLWR_n)   wr_q.push_back(USB3_DQ);
        if (!USB3_PKTEND_n) pend_cnt++;
        if (pkt_done)       done_cnt++;
        if (type_err)       terr_cnt++;
        if (hdr_alias)      alias_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wrclock);
        #1;
    endtask

    task automatic request(input logic [4:0] t);
        pkt_req  = 1'b1;
        pkt_type = t;
        tick();
        pkt_req  = 1'b0;
    endtask

    task automatic wait_pop(input int n);
        int guard = 0;
        while (src_pos != n && guard < 50) begin
            tick();
            guard++;
        end
        if (src_pos != n) check("pop_timeout", 32'(src_pos), 32'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dq"},     USB3_DQ,       32'h0);
        check({tag, "_slwr"},   USB3_SLWR_n,   32'h1);
        check({tag, "_pkend"},  USB3_PKTEND_n, 32'h1);
        check({tag, "_busy"},   busy,          32'h0);
        check({tag, "_done"},   pkt_done,      32'h0);
        check({tag, "_terr"},   type_err,      32'h0);
        check({tag, "_alias"},  hdr_alias,     32'h0);
    endtask

    // mode: 0 plain, 1 FLAGB stall, 2 source underflow, 3 reset abort
    task automatic run_pkt(input string name, input logic [4:0] t, input logic [31:0] hdr,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int mode, input int exp_alias);
        int          wr0, pend0, done0, alias0, stall_len;
        logic [31:0] exp_q [$];
        logic [31:0] got;
        bit          found;
        src_words[0] = w0; src_words[1] = w1; src_words[2] = w2; src_words[3] = w3;
        src_base = pop_cnt;
        wr0 = wr_q.size(); pend0 = pend_cnt; done0 = done_cnt; alias0 = alias_cnt;
        request(t);
        @(negedge wrclock);
        check({name, "_busy_set"}, busy, 32'h1);
        tick();
        if (mode != 0) begin
            wait_pop(2);
            if (mode == 3) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({name, "_abort"});
                tick(); tick();
                rst_n = 1'b1;
                tick();
                check({name, "_no_pkend"}, 32'(pend_cnt - pend0), 32'h0);
                return;
            end
            stall_len = (mode == 1) ? 5 : 3;
            if (mode == 1) USB3_FLAGB = 1'b0; else src_hold = 1'b1;
            for (int i = 0; i < stall_len; i++) begin
                @(negedge wrclock);
                check({name, "_stall_rd"}, src_rd, 32'h0);
                if (i > 0) check({name, "_stall_slwr"}, USB3_SLWR_n, 32'h1);
                tick();
            end
            USB3_FLAGB = 1'b1;
            src_hold   = 1'b0;
        end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge wrclock);
            if (pkt_done) begin
                found = 1'b1;
                check({name, "_busy_clr"}, busy, 32'h0);
            end
        end
        if (!found) check({name, "_done_timeout"}, 32'h0, 32'h1);
        @(negedge wrclock);
        check({name, "_done_pulse"}, pkt_done, 32'h0);
        tick();
        exp_q = {hdr, w0, w1, w2, w3};
`ifdef TX_CSUM_EN
        exp_q.push_back(w0 + w1 + w2 + w3);
`endif
        check({name, "_len"}, 32'(wr_q.size() - wr0), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            got = (wr0 + i < wr_q.size()) ? wr_q[wr0 + i] : 32'hxxxx_xxxx;
            check($sformatf("%s_w%0d", name, i), got, exp_q[i]);
        end
        check({name, "_pkend"}, 32'(pend_cnt - pend0), 32'h1);
        check({name, "_ndone"}, 32'(done_cnt - done0), 32'h1);
        check({name, "_alias"}, 32'(alias_cnt - alias0), 32'(exp_alias));
        check({name, "_pops"},  32'(src_pos), 32'(PW));
    endtask

    task automatic err_req(input string name, input logic [4:0] t);
        int terr0, wr0;
        terr0 = terr_cnt;
        wr0   = wr_q.size();
        request(t);
        @(negedge wrclock);
        check({name, "_terr"}, type_err, 32'h1);
        check({name, "_busy"}, busy, 32'h0);
        repeat (4) tick();
        check({name, "_nterr"}, 32'(terr_cnt - terr0), 32'h1);
        check({name, "_nowr"},  32'(wr_q.size() - wr0), 32'h0);
        check({name, "_busy2"}, busy, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge wrclock);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        run_pkt("norm",  5'd1, 32'hFF0000FF, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0);
        run_pkt("type2", 5'd2, 32'hFF000AFF, 32'h10, 32'h20, 32'h30, 32'h40, 0, 0);
        run_pkt("type3", 5'd3, 32'hFF0AAAFF, 32'h5, 32'h6, 32'h7, 32'h8, 0, 0);
        run_pkt("type4", 5'd4, 32'hFFAAAAFF, 32'hDEADBEEF, 32'h0, 32'h1, 32'h2, 0, 0);
        run_pkt("type5", 5'd5, 32'hFF00AAFF, 32'h12345678, 32'h9, 32'hA, 32'hB, 0, 0);
        err_req("err0", 5'd0);
        err_req("err6", 5'd6);
        run_pkt("bp",    5'd1, 32'hFF0000FF, 32'd11, 32'd12, 32'd13, 32'd14, 1, 0);
        run_pkt("uflow", 5'd2, 32'hFF000AFF, 32'd21, 32'd22, 32'd23, 32'd24, 2, 0);
        run_pkt("alias", 5'd1, 32'hFF0000FF, 32'd7, 32'hFF1234FF, 32'hFF0000FE, 32'd8, 0, 1);
        run_pkt("abort", 5'd3, 32'hFF0AAAFF, 32'd31, 32'd32, 32'd33, 32'd34, 3, 0);
        run_pkt("fresh", 5'd4, 32'hFFAAAAFF, 32'd41, 32'd42, 32'd43, 32'd44, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
